// File: rtl/rns_conv_sequencer.sv
// Sequential reverse converter for the RNS moduli set
// {2^N-1, 2^N+1, 2^(2N)+1, 2^(2N+P)}.
// The high part Y is built in a 4N-bit one's-complement accumulator
// (arithmetic mod 2^(4N)-1). Every CRT constant reduces to a rotation,
// a replication or a bit inversion, so each term needs one end-around-carry adder.
//   Xh = X mod (2^(4N)-1)         = t1 + t2 + t3
//   Y  = (Xh - R4) * 2^-(2N+P)    (the inverse power is a rotate right)
//   X  = Y * 2^(2N+P) + R4
module rns_conv_sequencer #(
  parameter int N = 4,
  parameter int P = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       R1,
  input  logic [N:0]         R2,
  input  logic [2*N:0]       R3,
  input  logic [2*N+P-1:0]   R4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [6*N+P-1:0]   X,
  output logic               err
);

  localparam int W = 4*N;     // accumulator width, modulus 2^W-1
  localparam int K = 2*N+P;   // width of the binary channel

  typedef enum logic [2:0] {IDLE, T1, T2, T3, TK, FOLD, DONE} state_t;

  state_t          state;
  logic [N-1:0]    r1;
  logic [N:0]      r2;
  logic [2*N:0]    r3;
  logic [K-1:0]    r4;
  logic            bad;
  logic [W-1:0]    acc;

  // Rotate left inside the W-bit word; this multiplies by 2^s mod 2^W-1.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int s);
    return (v << s) | (v >> (W - s));
  endfunction

  // Channel 1: R1 * (M2*M3) * 2^(N-2). M2*M3 = (2^W-1)/(2^N-1) replicates R1 four times.
  logic [W-1:0] term1;
  assign term1 = rotl({4{r1}}, N-2);

  // Channel 2: R2 * (M1*M3) * -2^(2N-2). R2*(2^N-1) fits in 2N bits because R2 <= 2^N,
  // and multiplying by (2^(2N)+1) is replication.
  logic [2*N-1:0] u2;
  logic [W-1:0]   term2;
  assign u2    = {r2[N-1:0], {N{1'b0}}} - (2*N)'(r2);
  assign term2 = ~rotl({u2, u2}, 2*N-2);

  // Channel 3: R3 * (M1*M2) * -2^(W-1). R3*(2^(2N)-1) fits in W bits because R3 <= 2^(2N).
  logic [W-1:0] t3;
  logic [W-1:0] term3;
  assign t3    = {r3[2*N-1:0], {(2*N){1'b0}}} - W'(r3);
  assign term3 = ~rotl(t3, W-1);

  // Correction term: -R4 in one's complement.
  logic [W-1:0] termk;
  assign termk = ~W'(r4);

  // Select the term for the current step.
  logic [W-1:0] term;
  always_comb begin
    term = '0;
    case (state)
      T1:      term = term1;
      T2:      term = term2;
      T3:      term = term3;
      TK:      term = termk;
      default: term = '0;
    endcase
  end

  // End-around-carry add. The second carry cannot occur since the sum fits after one wrap.
  logic [W:0]   sum;
  logic [W-1:0] acc_next;
  assign sum      = {1'b0, acc} + {1'b0, term};
  assign acc_next = sum[W-1:0] + W'(sum[W]);

  // All-ones is the second encoding of zero; canonicalize it, then divide by 2^K.
  logic [W-1:0] acc_fold;
  logic [W-1:0] y;
  assign acc_fold = (&acc) ? '0 : acc;
  assign y        = rotl(acc_fold, W-K);

  // Sequencer: capture, four accumulate steps, fold, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      X         <= '0;
      acc       <= '0;
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
      r4        <= '0;
      bad       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r1       <= R1;
            r2       <= R2;
            r3       <= R3;
            r4       <= R4;
            bad      <= (&R1) || (R2[N] && |R2[N-1:0]) || (R3[2*N] && |R3[2*N-1:0]);
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= T1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        T1: begin acc <= acc_next; state <= T2;   end
        T2: begin acc <= acc_next; state <= T3;   end
        T3: begin acc <= acc_next; state <= TK;   end
        TK: begin acc <= acc_next; state <= FOLD; end
        FOLD: begin
          out_valid <= 1'b1;
          err       <= bad;
          X         <= bad ? '0 : {y, r4};
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            X         <= '0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rns_conv_sequencer.sv
// Bench for rns_conv_sequencer: directed cases, backpressure, mid-run reset,
// exhaustive N=2,P=0 sweep and random N=4,P=2 values. Residues come from forward
// reduction of a chosen X, so the expected result is that X.
module tb_rns_conv_sequencer;
  localparam int NA = 2, PA = 0, NB = 4, PB = 2;
  localparam longint unsigned MA = 64'd4080;
  localparam longint unsigned MB = 64'd65535 * 64'd1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err;
  logic [NA-1:0]          a_r1;
  logic [NA:0]            a_r2;
  logic [2*NA:0]          a_r3;
  logic [2*NA+PA-1:0]     a_r4;
  logic [6*NA+PA-1:0]     a_x;

  logic                   b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
  logic [NB-1:0]          b_r1;
  logic [NB:0]            b_r2;
  logic [2*NB:0]          b_r3;
  logic [2*NB+PB-1:0]     b_r4;
  logic [6*NB+PB-1:0]     b_x;

  rns_conv_sequencer #(.N(NA), .P(PA)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .R1(a_r1), .R2(a_r2), .R3(a_r3), .R4(a_r4),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .X(a_x), .err(a_err));

  rns_conv_sequencer #(.N(NB), .P(PB)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .R1(b_r1), .R2(b_r2), .R3(b_r3), .R4(b_r4),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .X(b_x), .err(b_err));

  int tests = 0;
  int fails = 0;

  typedef struct { logic [63:0] x; logic e; } exp_t;
  exp_t sb[$];

  function automatic logic ov(input bit s);  return s ? b_out_valid : a_out_valid; endfunction
  function automatic logic rdy(input bit s); return s ? b_in_ready  : a_in_ready;  endfunction
  function automatic logic eo(input bit s);  return s ? b_err       : a_err;       endfunction
  function automatic logic [63:0] xo(input bit s); return s ? 64'(b_x) : 64'(a_x); endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input bit s, input logic v);
    if (s) b_in_valid = v; else a_in_valid = v;
  endtask

  task automatic set_ready(input bit s, input logic v);
    if (s) b_out_ready = v; else a_out_ready = v;
  endtask

  // One conversion: drive residues, push expectation, wait for the result, pop and compare.
  // hold>0 keeps out_ready low for that many cycles once the result is up.
  task automatic conv(input bit s, input logic [63:0] r1, input logic [63:0] r2,
                      input logic [63:0] r3, input logic [63:0] r4,
                      input logic [63:0] xe, input logic ee, input int hold, input bit full);
    exp_t e;
    int   k;
    @(negedge clk);
    if (s) begin
      b_r1 = r1[NB-1:0]; b_r2 = r2[NB:0]; b_r3 = r3[2*NB:0]; b_r4 = r4[2*NB+PB-1:0];
    end else begin
      a_r1 = r1[NA-1:0]; a_r2 = r2[NA:0]; a_r3 = r3[2*NA:0]; a_r4 = r4[2*NA+PA-1:0];
    end
    set_valid(s, 1'b1);
    set_ready(s, hold == 0);
    k = 0;
    while (!rdy(s) && k < 20) begin @(negedge clk); k++; end
    check("in_ready_wait", 64'(k < 20), 64'd1);
    if (k >= 20) begin set_valid(s, 1'b0); return; end
    sb.push_back('{xe, ee});
    @(posedge clk);
    #1 set_valid(s, 1'b0);
    k = 0;
    do begin
      @(posedge clk);
      #1 k++;
      if (full && !ov(s)) check("busy_in_ready", 64'(rdy(s)), 64'd0);
    end while (!ov(s) && k < 20);
    // out_valid rises on the 5th edge, so a consumer sees it at the 6th.
    check("latency", 64'(k), 64'd5);
    e = sb.pop_front();
    check("x", xo(s), e.x);
    check("err", 64'(eo(s)), 64'(e.e));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", 64'(ov(s)), 64'd1);
        check("hold_x", xo(s), e.x);
        check("hold_in_ready", 64'(rdy(s)), 64'd0);
      end
      @(negedge clk);
      set_ready(s, 1'b1);
    end
    @(posedge clk);
    #1;
    if (full) begin
      check("after_valid", 64'(ov(s)), 64'd0);
      check("after_x", xo(s), 64'd0);
      check("after_err", 64'(eo(s)), 64'd0);
      check("after_in_ready", 64'(rdy(s)), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] x;
    bit seen;
    int k;
    a_in_valid = 0; a_out_ready = 1; a_r1 = '0; a_r2 = '0; a_r3 = '0; a_r4 = '0;
    b_in_valid = 0; b_out_ready = 1; b_r1 = '0; b_r2 = '0; b_r3 = '0; b_r4 = '0;

    // Reset state
    #1;
    check("rst_in_ready", 64'(a_in_ready), 64'd0);
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_x", 64'(a_x), 64'd0);
    check("rst_err", 64'(b_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("rel_in_ready", 64'(a_in_ready), 64'd1);

    // Directed N=2,P=0
    conv(0, 1, 0, 15, 4,  100, 0, 0, 1);
    conv(0, 2, 4, 16, 15, 4079, 0, 0, 1);
    conv(0, 0, 0, 0, 0,   0, 0, 0, 1);
    conv(0, 3, 0, 0, 0,   0, 1, 0, 1);
    conv(0, 0, 6, 0, 0,   0, 1, 0, 1);
    conv(0, 0, 0, 20, 0,  0, 1, 0, 1);
    // Backpressure
    conv(0, 1, 0, 15, 4,  100, 0, 10, 1);

    // Reset while in T3
    @(negedge clk);
    a_r1 = 2'd2; a_r2 = 3'd4; a_r3 = 5'd16; a_r4 = 4'd15; a_in_valid = 1;
    k = 0;
    while (!a_in_ready && k < 20) begin @(negedge clk); k++; end
    check("rst_mid_hs", 64'(k < 20), 64'd1);
    @(posedge clk);
    #1 a_in_valid = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(a_out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(a_in_ready), 64'd0);
    check("mid_rst_x", 64'(a_x), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("mid_rel_in_ready", 64'(a_in_ready), 64'd1);
    seen = 0;
    repeat (10) begin @(posedge clk); #1 if (a_out_valid) seen = 1; end
    check("no_stale_result", 64'(seen), 64'd0);
    conv(0, 1, 0, 15, 4, 100, 0, 0, 1);

    // Exhaustive N=2,P=0
    for (int i = 0; i < int'(MA); i++)
      conv(0, i % 3, i % 5, i % 17, i % 16, i, 0, 0, 0);

    // N=4,P=2: bounds, range errors, random values
    conv(1, 0, 0, 0, 0, 0, 0, 0, 1);
    x = MB - 1;
    conv(1, x % 15, x % 17, x % 257, x % 1024, x, 0, 0, 1);
    conv(1, 15, 0, 0, 0, 0, 1, 0, 1);
    conv(1, 0, 17, 0, 0, 0, 1, 0, 1);
    conv(1, 0, 0, 257, 0, 0, 1, 3, 1);
    for (int i = 0; i < 300; i++) begin
      x = {$urandom, $urandom} % MB;
      conv(1, x % 15, x % 17, x % 257, x % 1024, x, 0, 0, 0);
    end

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
